// File: rtl/hazard_flush_ctrl.sv
// Pipeline sequencing controller: load-use stalls and branch/jump squashing.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_flush_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 2
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic [4:0]  ex_WriteReg,
    input  logic        ex_MemRead,
    input  logic [2:0]  ex_jump,
    input  logic        mem_PCSrc,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic [1:0]  ctrl_state,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
);

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_STALL      = 2'd1,
        S_RESET_HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               load_use;

    // A $zero destination is never a real producer.
    assign load_use = ex_MemRead && (ex_WriteReg != 5'd0) &&
                      ((ex_WriteReg == id_rs) ||
                       (id_uses_rt && (ex_WriteReg == id_rt)));

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= S_RESET_HOLD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (mem_PCSrc) begin
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                end else if (ex_jump != 3'd0) begin
                    ifid_flush = 1'b1;
                end else if (load_use) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_d = S_STALL;
                        cnt_d   = CNT_W'(LOAD_STALL_CYCLES - 1);
                    end
                end
            end
            S_STALL: begin
                // EX holds a bubble here, so only a branch can cut the stall short.
                if (mem_PCSrc) begin
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    state_d     = S_RUN;
                    cnt_d       = '0;
                end else begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                state_d     = S_RUN;
                cnt_d       = '0;
            end
        endcase
    end

    assign ctrl_state = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic        stall_evt, flush_evt;

    assign stall_evt = !pc_write && (state_q != S_RESET_HOLD);
    assign flush_evt = ((state_q == S_RUN) &&
                        (mem_PCSrc || (ex_jump != 3'd0))) ||
                       ((state_q == S_STALL) && mem_PCSrc);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_evt && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (flush_evt && (flush_cnt_q != 32'hFFFF_FFFF))
            flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign stall_count = 32'd0;
    assign flush_count = 32'd0;
`endif

endmodule

// File: doc/hazard_flush_ctrl.md
Name: hazard_flush_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS datapath. It drives the write-enable and flush inputs of the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Detects load-use hazards and stalls for a configurable number of cycles.
- Squashes wrong-path instructions on taken branches (resolved in MEM) and jumps (resolved in EX).
- Sits beside the hazard/forwarding logic. Its flush outputs connect directly to the pipeline registers' flush inputs.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1 = forwarding present, 2 = no MEM->EX forwarding); legal 1..3.
- CNT_W, 2, width of the internal stall counter.

Ports:
- clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- id_rs  input  5  rs field of instruction in ID
- id_rt  input  5  rt field of instruction in ID
- id_uses_rt  input  1  ID instruction reads rt as a source
- ex_WriteReg  input  5  destination register of instruction in EX
- ex_MemRead  input  1  EX instruction is a load
- ex_jump  input  3  jump code in EX; nonzero = jump taken
- mem_PCSrc  input  1  branch taken, resolved in MEM
- pc_write  output  1  PC register load enable
- ifid_write  output  1  IF/ID load enable
- ifid_flush  output  1  clear IF/ID
- idex_flush  output  1  clear ID/EX (bubble insert)
- exmem_flush  output  1  clear EX/MEM
- ctrl_state  output  2  0=RUN, 1=STALL, 2=RESET_HOLD
- stall_count  output  32  perf counter (see Optional Feature)
- flush_count  output  32  perf counter (see Optional Feature)

Behaviour:
- Registered state: state (2b) and cnt (CNT_W). All outputs are combinational from state and the inputs (Mealy). Perf counters are registered.
- Reset=1 at a clock edge: state<=RESET_HOLD, cnt<=0, counters<=0.
- While in RESET_HOLD: pc_write=0, ifid_write=0, and all three flushes=1.
- RESET_HOLD -> RUN on the first edge with Reset=0.
- load_use = ex_MemRead && ex_WriteReg!=0 && (ex_WriteReg==id_rs || (id_uses_rt && ex_WriteReg==id_rt)). A $zero destination never stalls.
- RUN, priority order:
  1. mem_PCSrc=1: ifid_flush=idex_flush=exmem_flush=1, pc_write=1, ifid_write=1; stay RUN. Any detected hazard is ignored because the instruction is squashed.
  2. ex_jump!=0: ifid_flush=1, idex_flush=0, exmem_flush=0, pc_write=1, ifid_write=1; stay RUN.
  3. load_use: pc_write=0, ifid_write=0, idex_flush=1. If LOAD_STALL_CYCLES>1: state<=STALL, cnt<=LOAD_STALL_CYCLES-1. Otherwise stay RUN.
  4. Otherwise: pc_write=1, ifid_write=1, no flushes.
- STALL:
  - Default: pc_write=0, ifid_write=0, idex_flush=1. cnt decrements each cycle; when cnt==1, state<=RUN, cnt<=0.
  - mem_PCSrc=1 in STALL: branch wins. Apply the full flush with pc_write=1, state<=RUN, cnt<=0. The stall is abandoned.
  - ex_jump is ignored in STALL because EX holds a bubble.
- Back-to-back load_use after a stall completes re-enters the stall normally.
- Latency:
  - Hazard response is same-cycle (combinational).
  - Total bubbles per load-use = LOAD_STALL_CYCLES exactly.
- Reset asserted mid-STALL: next edge state=RESET_HOLD and cnt=0; no residual stall after release.
- ctrl_state reflects the registered state.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_count increments on every cycle with pc_write=0 while state!=RESET_HOLD.
  - flush_count increments on every cycle where mem_PCSrc or a RUN-state jump flush is applied.
  - Both counters saturate at 32'hFFFFFFFF and clear on Reset.
- Undefined: both ports drive constant 0 and no counter flops are built.

Test Plan:
- Reset held 3 cycles, then released -> outputs pc_write=0 and all flushes=1 during hold; ctrl_state=0 and pc_write=1 one edge after release.
- LOAD_STALL_CYCLES=1, ex_MemRead=1, ex_WriteReg=8, id_rs=8 -> exactly 1 cycle of pc_write=0, ifid_write=0, idex_flush=1; ex_WriteReg=0 with id_rs=0 -> no stall.
- LOAD_STALL_CYCLES=2, load_use with ex_WriteReg=9, id_rt=9, id_uses_rt=1 -> 2 bubble cycles, ctrl_state=1 for one cycle; same case with id_uses_rt=0 -> no stall.
- mem_PCSrc=1 in the same cycle as load_use -> all three flushes=1, pc_write=1, no stall; mem_PCSrc=1 on the second cycle of STALL -> full flush, ctrl_state=0 next cycle.
- ex_jump=3'b001 -> ifid_flush=1 only for one cycle, pc_write=1; with HAZARD_PERF_CNT_EN defined: after 1 jump and 2 stall cycles, flush_count=1 and stall_count=2.
- Reset asserted on the first cycle of a 2-cycle stall -> RESET_HOLD next edge, no stall after release; perf counters read 0.
